board_7segment_decoder: RTL and testbench
=========================================

# board_7segment_decoder

Converts the 10-bit slide-switch value into four decimal digits (0000–1023) and drives four active-low 7-segment displays (thousands, hundreds, tens, units). It sits between the board switch inputs and the HEX display pins, alongside the top-level FSM. Conversion is a sequential shift-and-add-3 (double-dabble) engine, and the display registers refresh once per conversion frame.

## Interface
Parameters: none (widths fixed; constants in package).
- clk_50M  input  1  system clock, 50 MHz
- rst_bar  input  1  synchronous active-low reset, sampled on rising clk_50M
- sw  input  10  unsigned binary value, 0..1023
- seg_1000  output  7  thousands digit, active-low, bit0=a … bit6=g
- seg_100  output  7  hundreds digit, same encoding
- seg_10  output  7  tens digit, same encoding
- seg_1  output  7  units digit, same encoding

## Operation
- FSM states:
  - LOAD: capture sw into a 10-bit shift register; clear the 16-bit BCD accumulator; go to SHIFT.
  - SHIFT: 10 iterations. Each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. An iteration counter 0..9 controls the state; after the 10th shift, go to UPDATE.
  - UPDATE: encode the four BCD nibbles into the output registers; go to LOAD.
- Free-running: no start or valid handshake; frames repeat continuously.
- sw is sampled only in LOAD. Changes during SHIFT/UPDATE affect the next frame only.
- Segment patterns (gfedcba, active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - Blank=0x7F
- Any nibble >9 encodes as Blank. This cannot occur for 10-bit input; it is defensive only.
- The thousands digit is only ever 0 or 1.
- Outputs are registers only; no combinational path from sw to the segment outputs.

## Timing
- Frame length is 12 cycles: LOAD 1 + SHIFT 10 + UPDATE 1.
- Latency: sw captured at LOAD edge N; new segments visible after edge N+11.
- Outputs hold stable for 12 cycles between updates.
- Reset (rst_bar=0 at a rising edge), dominates all other activity:
  - state←LOAD, counter←0, shift/BCD registers←0.
  - Outputs: seg_1=0x40; seg_1000/seg_100/seg_10 = 0x40 (0x7F with blanking enabled).
- Reset mid-conversion aborts the frame; outputs take reset values, not partial results.
- First post-reset update occurs 12 cycles after rst_bar is sampled high.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - In UPDATE, a leading-zero digit outputs Blank (0x7F).
  - seg_1000 blanks when its digit is 0; seg_100 blanks when thousands and hundreds are both 0; seg_10 blanks when thousands, hundreds and tens are all 0.
  - seg_1 is never blanked.
- Undefined: all four digits always displayed, including leading zeros.

## Structure
- Package board_7seg_pkg contains:
  - SW_W=10, BCD_DIGITS=4, CONV_CYCLES=10
  - State enum {LOAD, SHIFT, UPDATE}
  - The ten digit patterns plus SEG_BLANK as 7-bit constants
- One sub-module, seg7_encode: combinational 4-bit digit → 7-bit active-low pattern, instantiated four times.

## Test plan
- Reset: hold rst_bar=0 for 3 cycles → all outputs 0x40 (macro off) or seg_1=0x40 and others 0x7F (macro on).
- sw=1023 → after 12 cycles: seg_1000=0x79, seg_100=0x40, seg_10=0x24, seg_1=0x30.
- sw=509 → "0509": seg_1000=0x40 (0x7F with macro), seg_100=0x12, seg_10=0x40, seg_1=0x10.
- sw=7 with macro on → seg_1000/100/10=0x7F, seg_1=0x78; sw=0 → seg_1=0x40, others 0x7F.
- sw changes 8→900 at the 5th SHIFT cycle → current frame shows "0008"; next frame shows "0900".
- rst_bar=0 for one cycle mid-SHIFT while displaying 1023 → outputs return to reset values the next cycle; correct value reappears 12 cycles after release.

Source files
------------

// File: rtl/board_7seg_pkg.sv
// Shared constants, FSM state type and BCD adjust helper for the 7-segment decoder.
// Optional feature macro used by the top: LEADING_ZERO_BLANK_EN.
package board_7seg_pkg;

  localparam int unsigned SW_W        = 10;
  localparam int unsigned BCD_DIGITS  = 4;
  localparam int unsigned CONV_CYCLES = 10;
  localparam int unsigned BCD_W       = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    UPDATE
  } state_e;

  // Active-low patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble pre-shift correction: every nibble >= 5 gets +3
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_encode
  import board_7seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/board_7segment_decoder.sv
// Switch value to four active-low 7-segment digits via a free-running 12-cycle double-dabble frame.
// Define LEADING_ZERO_BLANK_EN to blank leading-zero digits (units digit always shown).
module board_7segment_decoder
  import board_7seg_pkg::*;
(
  input  logic            clk_50M,
  input  logic            rst_bar,
  input  logic [SW_W-1:0] sw,
  output logic [6:0]      seg_1000,
  output logic [6:0]      seg_100,
  output logic [6:0]      seg_10,
  output logic [6:0]      seg_1
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_RST_LEAD = SEG_BLANK;
`else
  localparam logic [6:0] SEG_RST_LEAD = SEG_0;
`endif

  localparam logic [3:0] CNT_LAST = 4'(CONV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SW_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [6:0]       seg_1000_q, seg_1000_d;
  logic [6:0]       seg_100_q, seg_100_d;
  logic [6:0]       seg_10_q, seg_10_d;
  logic [6:0]       seg_1_q, seg_1_d;

  logic [6:0] enc_1000, enc_100, enc_10, enc_1;
  logic       blank_1000, blank_100, blank_10;

  seg7_encode u_enc_1000 (.digit(bcd_q[15:12]), .seg(enc_1000));
  seg7_encode u_enc_100  (.digit(bcd_q[11:8]),  .seg(enc_100));
  seg7_encode u_enc_10   (.digit(bcd_q[7:4]),   .seg(enc_10));
  seg7_encode u_enc_1    (.digit(bcd_q[3:0]),   .seg(enc_1));

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_1000 = (bcd_q[15:12] == 4'd0);
    blank_100  = blank_1000 && (bcd_q[11:8] == 4'd0);
    blank_10   = blank_100  && (bcd_q[7:4]  == 4'd0);
`else
    blank_1000 = 1'b0;
    blank_100  = 1'b0;
    blank_10   = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    seg_1000_d = seg_1000_q;
    seg_100_d  = seg_100_q;
    seg_10_d   = seg_10_q;
    seg_1_d    = seg_1_q;
    case (state_q)
      LOAD: begin
        bin_d   = sw;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        seg_1000_d = blank_1000 ? SEG_BLANK : enc_1000;
        seg_100_d  = blank_100  ? SEG_BLANK : enc_100;
        seg_10_d   = blank_10   ? SEG_BLANK : enc_10;
        seg_1_d    = enc_1;
        state_d    = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_bar) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      seg_1000_q <= SEG_RST_LEAD;
      seg_100_q  <= SEG_RST_LEAD;
      seg_10_q   <= SEG_RST_LEAD;
      seg_1_q    <= SEG_0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      seg_1000_q <= seg_1000_d;
      seg_100_q  <= seg_100_d;
      seg_10_q   <= seg_10_d;
      seg_1_q    <= seg_1_d;
    end
  end

  assign seg_1000 = seg_1000_q;
  assign seg_100  = seg_100_q;
  assign seg_10   = seg_10_q;
  assign seg_1    = seg_1_q;

endmodule

// File: tb/tb_board_7segment_decoder.sv
// Self-checking bench: frame-timed scoreboard of expected digit patterns plus reset/hold/mid-frame cases.
module tb_board_7segment_decoder;

  logic       clk_50M = 1'b0;
  logic       rst_bar = 1'b0;
  logic [9:0] sw      = '0;
  logic [6:0] seg_1000, seg_100, seg_10, seg_1;

  board_7segment_decoder dut (
    .clk_50M (clk_50M),
    .rst_bar (rst_bar),
    .sw      (sw),
    .seg_1000(seg_1000),
    .seg_100 (seg_100),
    .seg_10  (seg_10),
    .seg_1   (seg_1)
  );

  always #10 clk_50M = ~clk_50M;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] RST_LEAD = 7'h7F;
`else
  localparam logic [6:0] RST_LEAD = 7'h40;
`endif
  localparam logic [27:0] RST_SEGS = {RST_LEAD, RST_LEAD, RST_LEAD, 7'h40};

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [9:0]  sw;
    logic [15:0] bcd;
  } vec_t;
  vec_t vecs[10];

  int compared   = 0;
  int mismatched = 0;
  int phase      = 0;
  logic [15:0] exp_bcd = '0;
  string       tag = "init";
  logic [27:0] sb_q[$];

  function automatic logic [6:0] enc(input logic [3:0] d);
    return (d > 4'd9) ? 7'h7F : pat[d];
  endfunction

  function automatic logic [27:0] model(input logic [15:0] b);
    logic z3, z2, z1;
    z3 = 1'b0; z2 = 1'b0; z1 = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    z3 = (b[15:12] == 4'd0);
    z2 = z3 && (b[11:8] == 4'd0);
    z1 = z2 && (b[7:4] == 4'd0);
`endif
    return {z3 ? 7'h7F : enc(b[15:12]), z2 ? 7'h7F : enc(b[11:8]),
            z1 ? 7'h7F : enc(b[7:4]), enc(b[3:0])};
  endfunction

  function automatic logic [27:0] outs();
    return {seg_1000, seg_100, seg_10, seg_1};
  endfunction

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h_%h_%h_%h want %h_%h_%h_%h", name,
               got[27:21], got[20:14], got[13:7], got[6:0],
               want[27:21], want[20:14], want[13:7], want[6:0]);
    end
  endtask

  // One clock: push expectation at each LOAD edge, compare at each UPDATE edge.
  task automatic step();
    logic was_rst;
    was_rst = !rst_bar;
    if (!was_rst && phase == 0) sb_q.push_back(model(exp_bcd));
    @(posedge clk_50M);
    #1;
    if (was_rst) begin
      phase = 0;
      sb_q.delete();
    end else if (phase == 11) begin
      phase = 0;
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL %s: got update with empty scoreboard, want queued frame", tag);
      end else begin
        check(tag, outs(), sb_q.pop_front());
      end
    end else begin
      phase++;
    end
  endtask

  task automatic to_load();
    for (int k = 0; k < 12 && phase != 0; k++) step();
  endtask

  task automatic frame(input logic [9:0] v, input logic [15:0] b);
    to_load();
    sw = v; exp_bcd = b; tag = $sformatf("frame_sw%0d", v);
    repeat (12) step();
  endtask

  initial begin
    vecs[0] = '{10'd1023, 16'h1023};
    vecs[1] = '{10'd509,  16'h0509};
    vecs[2] = '{10'd7,    16'h0007};
    vecs[3] = '{10'd0,    16'h0000};
    vecs[4] = '{10'd1000, 16'h1000};
    vecs[5] = '{10'd10,   16'h0010};
    vecs[6] = '{10'd100,  16'h0100};
    vecs[7] = '{10'd999,  16'h0999};
    vecs[8] = '{10'd555,  16'h0555};
    vecs[9] = '{10'd864,  16'h0864};

    rst_bar = 1'b0;
    repeat (3) step();
    check("reset", outs(), RST_SEGS);
    rst_bar = 1'b1;

    for (int i = 0; i < 10; i++) frame(vecs[i].sw, vecs[i].bcd);

    // Outputs must hold through the following frame
    frame(10'd1023, 16'h1023);
    sw = 10'd0; exp_bcd = 16'h0000; tag = "frame_sw0_after_hold";
    repeat (6) step();
    check("hold", outs(), model(16'h1023));
    repeat (6) step();

    // sw changes during SHIFT: current frame keeps the old value
    to_load();
    sw = 10'd8; exp_bcd = 16'h0008; tag = "frame_sw8_changed";
    repeat (6) step();
    sw = 10'd900; exp_bcd = 16'h0900;
    repeat (6) step();
    tag = "frame_sw900_next";
    repeat (12) step();

    // One-cycle reset mid-SHIFT while 1023 is displayed
    frame(10'd1023, 16'h1023);
    repeat (4) step();
    rst_bar = 1'b0;
    step();
    check("mid_reset", outs(), RST_SEGS);
    rst_bar = 1'b1;
    tag = "frame_sw1023_after_reset";
    repeat (11) step();
    check("pre_update", outs(), RST_SEGS);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
